// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the instruction-memory loader.
//   state_t             - loader FSM state encoding
//   DEPTH_WORDS_DEFAULT - default instruction memory depth (32-bit words)
//   HDR_BYTES           - length header size in bytes (LEN_LO, LEN_HI)
//   BYTES_PER_WORD      - data bytes packed into one instruction word
//   csum_update()       - running XOR checksum step
package loader_pkg;

  localparam int DEPTH_WORDS_DEFAULT = 256;
  localparam int HDR_BYTES           = 2;
  localparam int BYTES_PER_WORD      = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/word_packer.sv
// word_packer: assembles accepted data bytes into little-endian 32-bit words.
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - synchronous restart of the byte counter at load start
//   byte_valid  - a data byte is transferred this cycle
//   byte_in     - the data byte
//   last_byte   - combinational: this transfer completes a word
//   word_valid  - registered one-cycle pulse carrying a completed word
//   word        - registered completed word (first byte in bits 7:0)
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;
  logic        r_word_valid;
  logic [31:0] r_word;

  assign last_byte  = byte_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));
  assign word_valid = r_word_valid;
  assign word       = r_word;

  // Byte shift register, byte counter and word output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= 2'd0;
      r_shift      <= 24'd0;
      r_word_valid <= 1'b0;
      r_word       <= 32'd0;
    end else if (clear) begin
      r_cnt        <= 2'd0;
      r_shift      <= 24'd0;
      r_word_valid <= 1'b0;
    end else if (last_byte) begin
      // Earlier bytes were shifted in from the top, so they already sit
      // little-endian in r_shift; the fourth byte lands in bits 31:24.
      r_word       <= {byte_in, r_shift};
      r_word_valid <= 1'b1;
      r_cnt        <= 2'd0;
      r_shift      <= 24'd0;
    end else if (byte_valid) begin
      r_shift      <= {byte_in, r_shift[23:8]};
      r_cnt        <= r_cnt + 2'd1;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes it into instruction memory while holding the CPU in reset.
//   clk, reset  - clock, asynchronous active-high reset
//   start       - pulse that begins a load (honoured in IDLE/DONE/ERROR)
//   rx_valid/rx_data/rx_ready - byte handshake with the source
//   imem_we/imem_addr/imem_wdata - one-cycle instruction-memory write
//   cpu_hold    - keeps the processor in reset until a good image loads
//   done        - image loaded and checksum matched
//   error       - bad length or checksum mismatch
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_t            r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_widx;
  logic [7:0]        r_csum;
  logic [ADDR_W-1:0] r_addr;
  logic              r_hold;
  logic              r_done;
  logic              r_error;

  logic              w_xfer;
  logic              w_data_byte;
  logic              w_clear;
  logic              w_last_byte;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [15:0]       w_len;
  logic              w_len_bad;

  // rx_ready is decoded from state so it stays high across write pulses.
  always_comb begin
    case (r_state)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM: rx_ready = 1'b1;
      default:                                rx_ready = 1'b0;
    endcase
  end

  assign w_xfer      = rx_valid && rx_ready;
  assign w_data_byte = w_xfer && (r_state == ST_DATA);
  assign w_clear     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                 (r_state == ST_ERROR));
  assign w_len       = {rx_data, r_len[7:0]};
  assign w_len_bad   = (w_len == 16'd0) || (32'(w_len) > 32'(DEPTH_WORDS));

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_clear),
    .byte_valid (w_data_byte),
    .byte_in    (rx_data),
    .last_byte  (w_last_byte),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  assign imem_we    = w_word_valid;
  assign imem_wdata = w_word;
  assign imem_addr  = r_addr;
  assign cpu_hold   = r_hold;
  assign done       = r_done;
  assign error      = r_error;

  // Loader FSM with length check, word index and running checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_len   <= 16'd0;
      r_widx  <= 16'd0;
      r_csum  <= 8'd0;
      r_addr  <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_state <= ST_LEN_LO;
            r_len   <= 16'd0;
            r_widx  <= 16'd0;
            r_csum  <= 8'd0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        ST_LEN_LO: begin
          if (w_xfer) begin
            r_len   <= {8'd0, rx_data};
            r_state <= ST_LEN_HI;
          end else begin
            r_state <= ST_LEN_LO;
          end
        end
        ST_LEN_HI: begin
          if (w_xfer) begin
            r_len <= w_len;
            if (w_len_bad) begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_state <= ST_LEN_HI;
          end
        end
        ST_DATA: begin
          if (w_data_byte) begin
            r_csum <= csum_update(r_csum, rx_data);
            if (w_last_byte) begin
              // Address is captured alongside the packer's word register so
              // both are valid together during the write pulse.
              r_addr <= r_widx[ADDR_W-1:0];
              r_widx <= r_widx + 16'd1;
              if (r_widx == (r_len - 16'd1)) begin
                r_state <= ST_CSUM;
              end else begin
                r_state <= ST_DATA;
              end
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_state <= ST_DATA;
          end
        end
        ST_CSUM: begin
          if (w_xfer) begin
            if (rx_data == r_csum) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
              r_hold  <= 1'b1;
            end
          end else begin
            r_state <= ST_CSUM;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_hold  <= 1'b1;
          r_done  <= 1'b0;
          r_error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;
  import loader_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Write monitor: each imem_we pulse is captured once at the falling edge.
  int          we_total = 0;
  logic [7:0]  we_addr [0:63];
  logic [31:0] we_data [0:63];

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_addr[we_total[5:0]] <= imem_addr;
      we_data[we_total[5:0]] <= imem_wdata;
      we_total               <= we_total + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte and hold it until accepted, with a bounded wait.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited   = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while ((rx_ready !== 1'b1) && (waited < 8)) begin
      tick();
      waited++;
    end
    if (rx_ready !== 1'b1) begin
      chk("ready_timeout", {31'd0, rx_ready}, 32'd1);
    end else begin
      tick();
    end
    rx_valid = 1'b0;
  endtask

  // Nominal image: two words 0x00000013, 0x001000B3.
  // Checksum is the XOR of data bytes: 13^00^00^00^B3^00^10^00 = B0.
  logic [7:0] img [0:7];
  int base;
  int c0;

  initial begin
    img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
    img[4] = 8'hB3; img[5] = 8'h00; img[6] = 8'h10; img[7] = 8'h00;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();
    tick();

    // Reset state.
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_we",       {31'd0, imem_we},  32'd0);
    chk("rst_addr",     {24'd0, imem_addr}, 32'd0);
    chk("rst_wdata",    imem_wdata,         32'd0);
    chk("rst_hold",     {31'd0, cpu_hold}, 32'd1);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_error",    {31'd0, error},    32'd0);
    reset = 1'b0;
    tick();

    // Nominal load, back-to-back: one byte per cycle for all 4*N+3 bytes.
    base = we_total;
    pulse_start();
    chk("start_ready", {31'd0, rx_ready}, 32'd1);
    c0 = cyc;
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_byte(img[i]);
    send_byte(8'hB0);
    chk("b2b_cycles", cyc - c0, HDR_BYTES + BYTES_PER_WORD * 2 + 1);
    chk("nom_writes", we_total - base, 32'd2);
    chk("nom_addr0",  {24'd0, we_addr[base[5:0]]}, 32'd0);
    chk("nom_data0",  we_data[base[5:0]], 32'h00000013);
    chk("nom_addr1",  {24'd0, we_addr[6'(base + 1)]}, 32'd1);
    chk("nom_data1",  we_data[6'(base + 1)], 32'h001000B3);
    chk("nom_done",   {31'd0, done},     32'd1);
    chk("nom_hold",   {31'd0, cpu_hold}, 32'd0);
    chk("nom_error",  {31'd0, error},    32'd0);
    chk("nom_ready",  {31'd0, rx_ready}, 32'd0);
    tick(); tick(); tick();
    chk("done_holds", {31'd0, done}, 32'd1);
    chk("done_no_we", we_total - base, 32'd2);

    // Bad checksum: writes still happen, then error.
    base = we_total;
    pulse_start();
    chk("restart_done_clr", {31'd0, done}, 32'd0);
    chk("restart_hold",     {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_byte(img[i]);
    send_byte(8'h00);
    chk("bad_writes", we_total - base, 32'd2);
    chk("bad_data1",  we_data[6'(base + 1)], 32'h001000B3);
    chk("bad_error",  {31'd0, error},    32'd1);
    chk("bad_hold",   {31'd0, cpu_hold}, 32'd1);
    chk("bad_done",   {31'd0, done},     32'd0);

    // Zero length.
    base = we_total;
    pulse_start();
    chk("err_clr", {31'd0, error}, 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    tick(); tick();
    chk("len0_error",  {31'd0, error},    32'd1);
    chk("len0_writes", we_total - base,   32'd0);
    chk("len0_ready",  {31'd0, rx_ready}, 32'd0);

    // 257 words exceeds 256-word memory.
    base = we_total;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    tick(); tick();
    chk("len257_error",  {31'd0, error},  32'd1);
    chk("len257_hold",   {31'd0, cpu_hold}, 32'd1);
    chk("len257_writes", we_total - base, 32'd0);

    // Throttled stream with a stray start mid-DATA.
    base = we_total;
    pulse_start();
    send_byte(8'h02); tick();
    send_byte(8'h00); tick();
    for (int i = 0; i < 8; i++) begin
      send_byte(img[i]);
      if (i == 4) pulse_start();
      else tick();
    end
    send_byte(8'hB0);
    chk("thr_writes", we_total - base, 32'd2);
    chk("thr_addr0",  {24'd0, we_addr[base[5:0]]}, 32'd0);
    chk("thr_data0",  we_data[base[5:0]], 32'h00000013);
    chk("thr_addr1",  {24'd0, we_addr[6'(base + 1)]}, 32'd1);
    chk("thr_data1",  we_data[6'(base + 1)], 32'h001000B3);
    chk("thr_done",   {31'd0, done},     32'd1);
    chk("thr_hold",   {31'd0, cpu_hold}, 32'd0);

    // Mid-load reset after 6 data bytes.
    base = we_total;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    chk("mid_pre_writes", we_total - base, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("mid_we",       {31'd0, imem_we},  32'd0);
    chk("mid_addr",     {24'd0, imem_addr}, 32'd0);
    chk("mid_wdata",    imem_wdata,         32'd0);
    chk("mid_hold",     {31'd0, cpu_hold}, 32'd1);
    chk("mid_done",     {31'd0, done},     32'd0);
    chk("mid_error",    {31'd0, error},    32'd0);
    tick(); tick();
    reset = 1'b0;
    base = we_total;
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx_data = 8'(i * 37 + 5);
      tick();
    end
    rx_valid = 1'b0;
    chk("post_rst_writes", we_total - base, 32'd0);
    chk("post_rst_ready",  {31'd0, rx_ready}, 32'd0);
    chk("post_rst_hold",   {31'd0, cpu_hold}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
